// File: rtl/lsu_pkg.sv
// Shared types and RV32 funct3 size codes for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic is_byte_access(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_BU);
  endfunction

  function automatic logic is_half_access(input logic [2:0] f3);
    return (f3 == F3_H) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data extraction: selects the addressed byte/half-word lane of the
// memory word and sign- or zero-extends it according to funct3.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[7:0];
    case (i_addr_lo)
      2'b00:   w_byte = i_word[7:0];
      2'b01:   w_byte = i_word[15:8];
      2'b10:   w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
  end

  assign w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

  // Reserved codes 011/110/111 fall through to a plain word access.
  always_comb begin
    o_result = i_word;
    case (i_funct3)
      F3_B:    o_result = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_result = {24'h000000, w_byte};
      F3_H:    o_result = {{16{w_half[15]}}, w_half};
      F3_HU:   o_result = {16'h0000, w_half};
      F3_W:    o_result = i_word;
      default: o_result = i_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between the execute stage and data memory.
// Build option LSU_MISALIGN_TRAP_EN: report misaligned accesses instead of force-aligning them.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_is_store,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_misaligned,
  output logic [31:0] o_mem_access_addr,
  output logic [31:0] o_mem_write_data,
  output logic        o_mem_write,
  output logic        o_mem_read,
  output logic        o_byte,
  output logic        o_half_word,
  output logic        o_full_word,
  output logic        o_byteU,
  output logic        o_half_wordU,
  input  logic [31:0] i_mem_read_data
);

  lsu_state_e  r_state, w_next;
  logic        w_accept, w_fault, w_is_byte, w_is_half;
  logic [31:0] w_req_addr, w_load_result;

  logic [1:0]  r_addr_lo;
  logic [2:0]  r_funct3;
  logic        r_is_store;
  logic [31:0] r_rsp_rdata, r_mem_addr, r_mem_wdata;
  logic        r_mem_write, r_mem_read;
  logic        r_byte, r_half_word, r_full_word, r_byteU, r_half_wordU;

  assign w_is_byte = is_byte_access(i_req_funct3);
  assign w_is_half = is_half_access(i_req_funct3);

`ifdef LSU_MISALIGN_TRAP_EN
  logic r_fault;

  assign w_req_addr = i_req_addr;
  assign w_fault    = (w_is_half && i_req_addr[0]) ||
                      (!w_is_byte && !w_is_half && (i_req_addr[1:0] != 2'b00));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      r_fault <= 1'b0;
    else if (w_accept) r_fault <= w_fault;
  end

  assign o_rsp_misaligned = r_fault && (r_state == ST_DONE);
`else
  // Without the trap the access is silently forced onto its natural boundary.
  assign w_fault    = 1'b0;
  assign w_req_addr = w_is_byte ? i_req_addr :
                      w_is_half ? {i_req_addr[31:1], 1'b0} :
                                  {i_req_addr[31:2], 2'b00};
  assign o_rsp_misaligned = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_req_valid) begin
          w_accept = 1'b1;
          w_next   = w_fault ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: w_next = r_is_store ? ST_DONE : ST_WAIT;
      ST_WAIT:  w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  lsu_load_align u_load_align (
    .i_word    (i_mem_read_data),
    .i_addr_lo (r_addr_lo),
    .i_funct3  (r_funct3),
    .o_result  (w_load_result)
  );

  // Strobes are loaded on the accept edge so they are registered and live only during ISSUE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr_lo    <= 2'b00;
      r_funct3     <= 3'b000;
      r_is_store   <= 1'b0;
      r_rsp_rdata  <= 32'h0;
      r_mem_addr   <= 32'h0;
      r_mem_wdata  <= 32'h0;
      r_mem_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_byte       <= 1'b0;
      r_half_word  <= 1'b0;
      r_full_word  <= 1'b0;
      r_byteU      <= 1'b0;
      r_half_wordU <= 1'b0;
    end else begin
      r_mem_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_byte       <= 1'b0;
      r_half_word  <= 1'b0;
      r_full_word  <= 1'b0;
      r_byteU      <= 1'b0;
      r_half_wordU <= 1'b0;
      if (w_accept) begin
        r_addr_lo   <= w_req_addr[1:0];
        r_funct3    <= i_req_funct3;
        r_is_store  <= i_req_is_store;
        r_rsp_rdata <= 32'h0;
        if (!w_fault) begin
          r_mem_addr  <= w_req_addr;
          r_mem_wdata <= i_req_wdata;
          r_mem_write <= i_req_is_store;
          r_mem_read  <= !i_req_is_store;
          case (i_req_funct3)
            F3_B:    r_byte       <= 1'b1;
            F3_H:    r_half_word  <= 1'b1;
            F3_BU:   r_byteU      <= 1'b1;
            F3_HU:   r_half_wordU <= 1'b1;
            default: r_full_word  <= 1'b1;
          endcase
        end
      end
      if (r_state == ST_WAIT) r_rsp_rdata <= w_load_result;
    end
  end

  assign o_req_ready       = (r_state == ST_IDLE);
  assign o_rsp_valid       = (r_state == ST_DONE);
  assign o_rsp_rdata       = r_rsp_rdata;
  assign o_mem_access_addr = r_mem_addr;
  assign o_mem_write_data  = r_mem_wdata;
  assign o_mem_write       = r_mem_write;
  assign o_mem_read        = r_mem_read;
  assign o_byte            = r_byte;
  assign o_half_word       = r_half_word;
  assign o_full_word       = r_full_word;
  assign o_byteU           = r_byteU;
  assign o_half_wordU      = r_half_wordU;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a registered-read memory model.
module tb_load_store_unit;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_misaligned;
  logic [31:0] rsp_rdata, mem_access_addr, mem_write_data, mem_read_data;
  logic        mem_write, mem_read, s_byte, s_half, s_full, s_byteu, s_halfu;
  logic [31:0] mem_word;
  logic [6:0]  strb;

  int n_checks = 0;
  int n_errors = 0;

  load_store_unit dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_req_valid      (req_valid),
    .o_req_ready      (req_ready),
    .i_req_is_store   (req_is_store),
    .i_req_funct3     (req_funct3),
    .i_req_addr       (req_addr),
    .i_req_wdata      (req_wdata),
    .o_rsp_valid      (rsp_valid),
    .o_rsp_rdata      (rsp_rdata),
    .o_rsp_misaligned (rsp_misaligned),
    .o_mem_access_addr(mem_access_addr),
    .o_mem_write_data (mem_write_data),
    .o_mem_write      (mem_write),
    .o_mem_read       (mem_read),
    .o_byte           (s_byte),
    .o_half_word      (s_half),
    .o_full_word      (s_full),
    .o_byteU          (s_byteu),
    .o_half_wordU     (s_halfu),
    .i_mem_read_data  (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory returns the word registered one cycle after mem_read, junk otherwise.
  always @(posedge clk) mem_read_data <= mem_read ? mem_word : 32'h5A5A5A5A;

  // {write, read, byte, half_word, full_word, byteU, half_wordU}
  assign strb = {mem_write, mem_read, s_byte, s_half, s_full, s_byteu, s_halfu};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request and check every cycle up to E0+4; lat is the cycle of rsp_valid.
  task automatic run_req(input string name, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] word, input int lat,
                         input logic [6:0] exp_strb, input logic [31:0] exp_addr,
                         input logic [31:0] exp_rdata, input logic exp_mis);
    @(negedge clk);
    mem_word     = word;
    req_is_store = st;
    req_funct3   = f3;
    req_addr     = addr;
    req_wdata    = wdata;
    req_valid    = 1'b1;
    check({name, ":ready_idle"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check({name, ":strb_issue"}, 32'(strb), 32'(exp_strb));
        check({name, ":ready_busy"}, 32'(req_ready), 32'd0);
        if (exp_strb != 7'd0) check({name, ":addr"}, mem_access_addr, exp_addr);
        if (st && exp_strb != 7'd0) check({name, ":wdata"}, mem_write_data, wdata);
      end
      if (k == 2) check({name, ":strb_after"}, 32'(strb), 32'd0);
      if (k == lat) begin
        check({name, ":rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({name, ":rdata"}, rsp_rdata, exp_rdata);
        check({name, ":misaligned"}, 32'(rsp_misaligned), 32'(exp_mis));
      end else begin
        check({name, ":rsp_idle"}, 32'(rsp_valid), 32'd0);
      end
    end
  endtask

  // Accept a load and pull reset in cycle E0+at_k (1 = ISSUE, 2 = WAIT).
  task automatic reset_mid(input string name, input int at_k);
    int pulses;
    @(negedge clk);
    mem_word     = 32'h11223344;
    req_is_store = 1'b0;
    req_funct3   = 3'b010;
    req_addr     = 32'h30;
    req_valid    = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= at_k; k++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check({name, ":strb_rst"}, 32'(strb), 32'd0);
    check({name, ":rsp_rst"}, 32'(rsp_valid), 32'd0);
    check({name, ":ready_rst"}, 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
    end
    check({name, ":no_rsp"}, 32'(pulses), 32'd0);
  endtask

  initial begin
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_is_store = 1'b0;
    req_funct3   = 3'b000;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    mem_word     = 32'h0;
    #3;
    check("rst:ready", 32'(req_ready), 32'd1);
    check("rst:rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst:rdata", rsp_rdata, 32'h0);
    check("rst:mis", 32'(rsp_misaligned), 32'd0);
    check("rst:strb", 32'(strb), 32'd0);
    check("rst:addr", mem_access_addr, 32'h0);
    check("rst:wdata", mem_write_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_req("LW",   1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 3, 7'b0100100, 32'h10, 32'hDEADBEEF, 1'b0);
    run_req("LB",   1'b0, 3'b000, 32'h13, 32'h0, 32'h80FF1234, 3, 7'b0110000, 32'h13, 32'hFFFFFF80, 1'b0);
    run_req("LBU",  1'b0, 3'b100, 32'h13, 32'h0, 32'h80FF1234, 3, 7'b0100010, 32'h13, 32'h00000080, 1'b0);
    run_req("LB0",  1'b0, 3'b000, 32'h10, 32'h0, 32'h80FF1234, 3, 7'b0110000, 32'h10, 32'h00000034, 1'b0);
    run_req("LB2",  1'b0, 3'b000, 32'h12, 32'h0, 32'h80FF1234, 3, 7'b0110000, 32'h12, 32'hFFFFFFFF, 1'b0);
    run_req("LH",   1'b0, 3'b001, 32'h22, 32'h0, 32'h9ABC0001, 3, 7'b0101000, 32'h22, 32'hFFFF9ABC, 1'b0);
    run_req("LHU",  1'b0, 3'b101, 32'h22, 32'h0, 32'h9ABC0001, 3, 7'b0100001, 32'h22, 32'h00009ABC, 1'b0);
    run_req("LHlo", 1'b0, 3'b001, 32'h20, 32'h0, 32'h9ABC8001, 3, 7'b0101000, 32'h20, 32'hFFFF8001, 1'b0);
    run_req("L011", 1'b0, 3'b011, 32'h24, 32'h0, 32'hCAFEF00D, 3, 7'b0100100, 32'h24, 32'hCAFEF00D, 1'b0);
    run_req("SB",   1'b1, 3'b000, 32'h40000004, 32'h000000A5, 32'h0, 2, 7'b1010000, 32'h40000004, 32'h0, 1'b0);
    run_req("SH",   1'b1, 3'b001, 32'h40000002, 32'h1234BEEF, 32'h0, 2, 7'b1001000, 32'h40000002, 32'h0, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
    run_req("SWmis",  1'b1, 3'b010, 32'h06, 32'h12345678, 32'h0, 1, 7'b0000000, 32'h0, 32'h0, 1'b1);
    run_req("LHUmis", 1'b0, 3'b101, 32'h23, 32'h0, 32'h9ABC0001, 1, 7'b0000000, 32'h0, 32'h0, 1'b1);
`else
    run_req("SWmis",  1'b1, 3'b010, 32'h06, 32'h12345678, 32'h0, 2, 7'b1000100, 32'h04, 32'h0, 1'b0);
    run_req("LHUmis", 1'b0, 3'b101, 32'h23, 32'h0, 32'h9ABC0001, 3, 7'b0100001, 32'h22, 32'h00009ABC, 1'b0);
`endif
    reset_mid("RST_ISSUE", 1);
    reset_mid("RST_WAIT", 2);
    run_req("LW2",  1'b0, 3'b010, 32'h10, 32'h0, 32'h0BADF00D, 3, 7'b0100100, 32'h10, 32'h0BADF00D, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
